// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and constants for the multi-read-port register file.
// Default geometry matches the legacy 32x32 MIPS file.
package reg_file_mp_pkg;
  localparam int RF_DATA_W_DEF   = 32;
  localparam int RF_NUM_REGS_DEF = 32;
  localparam int RF_NUM_RD_DEF   = 2;
  localparam int RF_MAX_RD       = 4;
  localparam int RF_ZERO_REG     = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard; 1-cycle update, no backpressure.
// A set and a clear on the same register in one cycle leaves it busy.
module rf_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS_DEF,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set,
  input  logic [ADDR_W-1:0]   set_reg,
  input  logic                clr,
  input  logic [ADDR_W-1:0]   clr_reg,
  output logic [NUM_REGS-1:0] busy
);

  // R0 is never written here, so it stays 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int r = RF_ZERO_REG + 1; r < NUM_REGS; r++) begin
        if (set && set_reg == ADDR_W'(r))
          busy[r] <= 1'b1;
        else if (clr && clr_reg == ADDR_W'(r))
          busy[r] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with hardwired R0 and busy scoreboard; reads are combinational.
// Optional write-through forwarding to the read ports when RF_BYPASS_EN is defined.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W_DEF,
  parameter int NUM_REGS = RF_NUM_REGS_DEF,
  parameter int NUM_RD   = RF_NUM_RD_DEF,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] readReg,
  output logic [NUM_RD*DATA_W-1:0] readData,
  output logic [NUM_RD-1:0]        readBusy,
  input  logic [ADDR_W-1:0]        writeReg,
  input  logic [DATA_W-1:0]        writeData,
  input  logic                     regWrite,
  input  logic                     setBusy,
  input  logic [ADDR_W-1:0]        setBusyReg
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_ok;

  assign wr_ok = regWrite && (writeReg != ADDR_W'(RF_ZERO_REG));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
    end else if (wr_ok) begin
      regs[writeReg] <= writeData;
    end
  end

  // Writes to R0 reach the scoreboard too, but it never tracks R0.
  rf_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set     (setBusy),
    .set_reg (setBusyReg),
    .clr     (regWrite),
    .clr_reg (writeReg),
    .busy    (busy)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] q_dat;
    logic              q_bsy;

    assign ra    = readReg[i*ADDR_W +: ADDR_W];
    assign q_dat = (ra == ADDR_W'(RF_ZERO_REG)) ? '0 : regs[ra];
    assign q_bsy = busy[ra];

`ifdef RF_BYPASS_EN
    logic hit;
    logic reserve;

    assign hit     = wr_ok && (ra == writeReg);
    // A new reservation in the same cycle keeps the registered busy view.
    assign reserve = setBusy && (setBusyReg == ra);
    assign readData[i*DATA_W +: DATA_W] = hit ? writeData : q_dat;
    assign readBusy[i] = (hit && !reserve) ? 1'b0 : q_bsy;
`else
    assign readData[i*DATA_W +: DATA_W] = q_dat;
    assign readBusy[i] = q_bsy;
`endif
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed plus random bench for reg_file_mp in two geometries against an array reference model.
module tb_reg_file_mp;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: 32x32, 2 read ports
  logic [9:0]  rr_a;
  logic [63:0] rd_a;
  logic [1:0]  rb_a;
  logic [4:0]  wa_a, sbr_a;
  logic [31:0] wd_a;
  logic        we_a, sb_a;

  // Instance B: 8x16, 4 read ports
  logic [11:0] rr_b;
  logic [63:0] rd_b;
  logic [3:0]  rb_b;
  logic [2:0]  wa_b, sbr_b;
  logic [15:0] wd_b;
  logic        we_b, sb_b;

  reg_file_mp dut_a (
    .clk(clk), .rst(rst), .readReg(rr_a), .readData(rd_a), .readBusy(rb_a),
    .writeReg(wa_a), .writeData(wd_a), .regWrite(we_a),
    .setBusy(sb_a), .setBusyReg(sbr_a)
  );

  reg_file_mp #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(4)) dut_b (
    .clk(clk), .rst(rst), .readReg(rr_b), .readData(rd_b), .readBusy(rb_b),
    .writeReg(wa_b), .writeData(wd_b), .regWrite(we_b),
    .setBusy(sb_b), .setBusyReg(sbr_b)
  );

  logic [31:0] ma [32];
  bit          ba [32];
  logic [15:0] mb [8];
  bit          bb [8];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data_a(input int a);
    if (a == 0) return 32'd0;
    if (BYP && we_a && wa_a != 0 && int'(wa_a) == a) return wd_a;
    return ma[a];
  endfunction

  function automatic logic exp_busy_a(input int a);
    if (a == 0) return 1'b0;
    if (BYP && we_a && wa_a != 0 && int'(wa_a) == a && !(sb_a && int'(sbr_a) == a)) return 1'b0;
    return ba[a];
  endfunction

  function automatic logic [15:0] exp_data_b(input int a);
    if (a == 0) return 16'd0;
    if (BYP && we_b && wa_b != 0 && int'(wa_b) == a) return wd_b;
    return mb[a];
  endfunction

  function automatic logic exp_busy_b(input int a);
    if (a == 0) return 1'b0;
    if (BYP && we_b && wa_b != 0 && int'(wa_b) == a && !(sb_b && int'(sbr_b) == a)) return 1'b0;
    return bb[a];
  endfunction

  // Check every port of both instances, then clock and advance the model.
  task automatic tick();
    #1;
    for (int i = 0; i < 2; i++) begin
      int a = int'(rr_a[i*5 +: 5]);
      chk($sformatf("A data p%0d r%0d", i, a), rd_a[i*32 +: 32], exp_data_a(a));
      chk($sformatf("A busy p%0d r%0d", i, a), {31'd0, rb_a[i]}, {31'd0, exp_busy_a(a)});
    end
    for (int i = 0; i < 4; i++) begin
      int a = int'(rr_b[i*3 +: 3]);
      chk($sformatf("B data p%0d r%0d", i, a), {16'd0, rd_b[i*16 +: 16]}, {16'd0, exp_data_b(a)});
      chk($sformatf("B busy p%0d r%0d", i, a), {31'd0, rb_b[i]}, {31'd0, exp_busy_b(a)});
    end
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) begin ma[r] = 32'd0; ba[r] = 1'b0; end
      for (int r = 0; r < 8; r++)  begin mb[r] = 16'd0; bb[r] = 1'b0; end
    end else begin
      if (we_a && wa_a != 0) begin ma[wa_a] = wd_a; ba[wa_a] = 1'b0; end
      if (sb_a && sbr_a != 0) ba[sbr_a] = 1'b1;
      if (we_b && wa_b != 0) begin mb[wa_b] = wd_b; bb[wa_b] = 1'b0; end
      if (sb_b && sbr_b != 0) bb[sbr_b] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    we_a = 0; sb_a = 0; wa_a = 0; wd_a = 0; sbr_a = 0;
    we_b = 0; sb_b = 0; wa_b = 0; wd_b = 0; sbr_b = 0;
  endtask

  task automatic sweep();
    for (int r = 0; r < 32; r++) begin
      rr_a = {5'(31 - r), 5'(r)};
      rr_b = {3'(r + 3), 3'(r + 2), 3'(r + 1), 3'(r)};
      tick();
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin ma[r] = 'x; ba[r] = 1'bx; end
    for (int r = 0; r < 8; r++)  begin mb[r] = 'x; bb[r] = 1'bx; end
    rst = 1; rr_a = 0; rr_b = 0; idle();
    // Give the model known state at the first reset edge.
    @(negedge clk);
    @(posedge clk);
    for (int r = 0; r < 32; r++) begin ma[r] = 32'd0; ba[r] = 1'b0; end
    for (int r = 0; r < 8; r++)  begin mb[r] = 16'd0; bb[r] = 1'b0; end
    #1;
    rst = 0;
    sweep();

    // R5 and R31 write then read
    we_a = 1; wa_a = 5; wd_a = 32'd10; tick();
    wa_a = 31; wd_a = 32'hFFFF_FFFF; tick();
    idle(); rr_a = {5'd31, 5'd5};
    #1;
    chk("R5 lit", rd_a[31:0], 32'd10);
    chk("R31 lit", rd_a[63:32], 32'hFFFF_FFFF);
    tick();

    // R0 write dropped, same and next cycle
    we_a = 1; wa_a = 0; wd_a = 32'd10; rr_a = 0;
    we_b = 1; wa_b = 0; wd_b = 16'd10; sb_b = 1; sbr_b = 0; rr_b = 0;
    sb_a = 1; sbr_a = 0;
    tick();
    idle(); tick();

    // Busy set, clear by write, set beats clear
    sb_a = 1; sbr_a = 7; rr_a = {5'd7, 5'd7}; tick();
    idle();
    #1;
    chk("R7 busy lit", {30'd0, rb_a}, 32'd3);
    tick();
    we_a = 1; wa_a = 7; wd_a = 32'd42; tick();
    idle();
    #1;
    chk("R7 clr lit", {30'd0, rb_a}, 32'd0);
    chk("R7 data lit", rd_a[31:0], 32'd42);
    tick();
    sb_a = 1; sbr_a = 7; we_a = 1; wa_a = 7; wd_a = 32'd5; tick();
    idle();
    #1;
    chk("R7 set wins lit", {30'd0, rb_a}, 32'd3);
    tick();
    sb_a = 1; sbr_a = 7; tick();  // re-set while busy
    idle(); tick();

    // Same-cycle write and read of R9
    we_a = 1; wa_a = 9; wd_a = 32'h1234; rr_a = {5'd9, 5'd9};
    we_b = 1; wa_b = 3; wd_b = 16'hBEEF; rr_b = {3'd3, 3'd3, 3'd3, 3'd3};
    tick();
    idle(); tick();

    // Fill with index values and busy, reset mid-fill
    for (int r = 1; r < 32; r++) begin
      we_a = 1; wa_a = 5'(r); wd_a = r; sb_a = 1; sbr_a = 5'(r);
      we_b = 1; wa_b = 3'(r); wd_b = 16'(r); sb_b = (r % 8) != 0; sbr_b = 3'(r);
      rr_a = {5'(r - 1), 5'(r)}; rr_b = {3'(r), 3'(r - 1), 3'(r + 1), 3'(r)};
      if (r == 20) rst = 1;
      tick();
      if (r == 20) break;
    end
    rst = 0; idle();
    sweep();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      we_a = $urandom_range(0, 1); wa_a = 5'($urandom); wd_a = $urandom;
      sb_a = $urandom_range(0, 1); sbr_a = ($urandom_range(0, 3) == 0) ? wa_a : 5'($urandom);
      rr_a = ($urandom_range(0, 2) == 0) ? {wa_a, wa_a} : 10'($urandom);
      we_b = $urandom_range(0, 1); wa_b = 3'($urandom); wd_b = 16'($urandom);
      sb_b = $urandom_range(0, 1); sbr_b = ($urandom_range(0, 3) == 0) ? wa_b : 3'($urandom);
      rr_b = ($urandom_range(0, 2) == 0) ? {wa_b, 3'($urandom), wa_b, 3'($urandom)} : 12'($urandom);
      tick();
    end
    rst = 0; idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
